sps_match_referee: RTL and testbench

- Parametrised successor to the single-round stone-paper-scissors FSM: referees a full best-of match between two players.
- Supports an N-move generalised game (3 = stone/paper/scissors, 5 = +lizard/spock, any odd N).
- Each player submits moves independently via a valid/ready handshake; the block keeps scores and a round count, and declares a match winner.
- Sits between the player input front-ends and the display/score logic.

---
 rtl/sps_match_referee.sv | 267 ++++++++++++++++++++++++++
 tb/tb_sps_match_referee.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sps_match_referee.sv
// sps_match_referee: best-of match referee for an N-move generalised
// stone/paper/scissors game. Two players hand in moves over independent
// valid/ready handshakes. Each round is judged, scores and a round count are
// kept, and the match ends on WIN_TARGET round wins or MAX_ROUNDS rounds.
//
// Optional build macro: SPS_TIMEOUT_EN
//   When it is defined, COLLECT gives up after TIMEOUT_CYCLES cycles and judges
//   the round with missing moves treated as invalid. debug[0] then carries the
//   timeout flag for that round.
//   When it is undefined, COLLECT waits indefinitely and no timer is built.
module sps_match_referee #(
    parameter int NUM_MOVES      = 3,
    parameter int MOVE_W         = 2,
    parameter int WIN_TARGET     = 3,
    parameter int MAX_ROUNDS     = 7,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start_match,
    input  logic              abort,
    input  logic [MOVE_W-1:0] p1_move,
    input  logic              p1_valid,
    output logic              p1_ready,
    input  logic [MOVE_W-1:0] p2_move,
    input  logic              p2_valid,
    output logic              p2_ready,
    output logic              round_valid,
    output logic [1:0]        round_winner,
    output logic [3:0]        p1_score,
    output logic [3:0]        p2_score,
    output logic [3:0]        round_cnt,
    output logic              match_done,
    output logic [1:0]        match_winner,
    output logic [2:0]        state,
    output logic [2:0]        debug
);

    localparam logic [2:0] ST_IDLE       = 3'b000;
    localparam logic [2:0] ST_COLLECT    = 3'b001;
    localparam logic [2:0] ST_EVAL       = 3'b010;
    localparam logic [2:0] ST_ROUND_DONE = 3'b011;
    localparam logic [2:0] ST_MATCH_DONE = 3'b100;

    localparam logic [1:0] RW_TIE  = 2'b00;
    localparam logic [1:0] RW_P1   = 2'b01;
    localparam logic [1:0] RW_P2   = 2'b10;
    localparam logic [1:0] RW_VOID = 2'b11;

    // One extra bit so (p1 + N - p2) never overflows during the modulo.
    localparam int              EW    = MOVE_W + 1;
    localparam logic [EW-1:0]   NM_W  = EW'(NUM_MOVES);
    localparam logic [EW-1:0]   HALF  = EW'((NUM_MOVES - 1) / 2);
    localparam logic [3:0]      WIN_W = 4'(WIN_TARGET);
    localparam logic [3:0]      MAX_W = 4'(MAX_ROUNDS);

    logic [2:0]        state_q, state_d;
    logic              p1_cap_q, p1_cap_d;
    logic              p2_cap_q, p2_cap_d;
    logic [MOVE_W-1:0] p1_move_q, p2_move_q;
    logic [3:0]        p1_score_q, p1_score_d;
    logic [3:0]        p2_score_q, p2_score_d;
    logic [3:0]        round_cnt_q, round_cnt_d;
    logic [1:0]        round_winner_q, round_winner_d;
    logic              invalid_q, invalid_d;

    logic              p1_fire, p2_fire, both_next;
    logic              clear_match, clear_all, match_over;
    logic              timeout_hit;
    logic              debug_lsb;

    logic              p1_bad, p2_bad;
    logic [EW-1:0]     p1_ext, p2_ext, diff;
    logic [1:0]        eval_winner;

    assign p1_fire     = (state_q == ST_COLLECT) && p1_valid && !p1_cap_q;
    assign p2_fire     = (state_q == ST_COLLECT) && p2_valid && !p2_cap_q;
    assign both_next   = (p1_cap_q || p1_fire) && (p2_cap_q || p2_fire);
    assign clear_match = start_match && ((state_q == ST_IDLE) || (state_q == ST_MATCH_DONE));
    assign clear_all   = clear_match || abort;
    assign match_over  = (p1_score_q == WIN_W) || (p2_score_q == WIN_W) || (round_cnt_q == MAX_W);

    // Round judgement: a missing or out-of-range move forfeits; otherwise the
    // modular distance between moves decides.
    always_comb begin
        p1_ext = {1'b0, p1_move_q};
        p2_ext = {1'b0, p2_move_q};
        p1_bad = !p1_cap_q || (p1_ext >= NM_W);
        p2_bad = !p2_cap_q || (p2_ext >= NM_W);
        diff   = (p1_ext >= p2_ext) ? (p1_ext - p2_ext) : (p1_ext + NM_W - p2_ext);
        if (p1_bad && p2_bad) begin
            eval_winner = RW_VOID;
        end else if (p1_bad) begin
            eval_winner = RW_P2;
        end else if (p2_bad) begin
            eval_winner = RW_P1;
        end else if (diff == '0) begin
            eval_winner = RW_TIE;
        end else if (diff <= HALF) begin
            eval_winner = RW_P1;
        end else begin
            eval_winner = RW_P2;
        end
    end

    // Next-state logic for the match controller; abort overrides everything.
    always_comb begin
        // NOTE: every signal gets a default here so no path leaves one unassigned (no latches).
        state_d        = state_q;
        p1_cap_d       = p1_cap_q;
        p2_cap_d       = p2_cap_q;
        p1_score_d     = p1_score_q;
        p2_score_d     = p2_score_q;
        round_cnt_d    = round_cnt_q;
        round_winner_d = round_winner_q;
        invalid_d      = invalid_q;

        case (state_q)
            ST_IDLE, ST_MATCH_DONE: begin
                if (start_match) begin
                    state_d = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (p1_fire) begin
                    p1_cap_d = 1'b1;
                end
                if (p2_fire) begin
                    p2_cap_d = 1'b1;
                end
                if (both_next || timeout_hit) begin
                    state_d = ST_EVAL;
                end
            end
            ST_EVAL: begin
                round_winner_d = eval_winner;
                invalid_d      = p1_bad || p2_bad;
                if (eval_winner != RW_VOID) begin
                    round_cnt_d = round_cnt_q + 4'd1;
                end
                if (eval_winner == RW_P1) begin
                    p1_score_d = p1_score_q + 4'd1;
                end
                if (eval_winner == RW_P2) begin
                    p2_score_d = p2_score_q + 4'd1;
                end
                state_d = ST_ROUND_DONE;
            end
            ST_ROUND_DONE: begin
                p1_cap_d = 1'b0;
                p2_cap_d = 1'b0;
                state_d  = match_over ? ST_MATCH_DONE : ST_COLLECT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (clear_all) begin
            p1_cap_d       = 1'b0;
            p2_cap_d       = 1'b0;
            p1_score_d     = 4'd0;
            p2_score_d     = 4'd0;
            round_cnt_d    = 4'd0;
            round_winner_d = RW_TIE;
            invalid_d      = 1'b0;
        end
        if (abort) begin
            state_d = ST_IDLE;
        end
    end

    // Control and score registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            p1_cap_q       <= 1'b0;
            p2_cap_q       <= 1'b0;
            p1_score_q     <= 4'd0;
            p2_score_q     <= 4'd0;
            round_cnt_q    <= 4'd0;
            round_winner_q <= RW_TIE;
            invalid_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q        <= state_d;
            p1_cap_q       <= p1_cap_d;
            p2_cap_q       <= p2_cap_d;
            p1_score_q     <= p1_score_d;
            p2_score_q     <= p2_score_d;
            round_cnt_q    <= round_cnt_d;
            round_winner_q <= round_winner_d;
            invalid_q      <= invalid_d;
        end
    end

    // Move holding registers, loaded only on a handshake.
    always_ff @(posedge clk) begin
        // NOTE: pure data, no reset needed; the capture flags qualify every use.
        if (p1_fire) begin
            p1_move_q <= p1_move;
        end
        if (p2_fire) begin
            p2_move_q <= p2_move;
        end
    end

`ifdef SPS_TIMEOUT_EN
    localparam int            TW     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_END = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          to_flag_q, to_flag_d;
    logic          unused_invalid;

    assign timeout_hit    = (state_q == ST_COLLECT) && (to_cnt_q == TO_END) && !both_next;
    assign debug_lsb      = to_flag_q;
    assign unused_invalid = invalid_q;

    // Collect timer: counts cycles spent in COLLECT and is zero on every entry.
    always_comb begin
        to_cnt_d  = '0;
        to_flag_d = to_flag_q;
        if ((state_q == ST_COLLECT) && (state_d == ST_COLLECT)) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
        if ((state_q == ST_COLLECT) && (state_d == ST_EVAL)) begin
            to_flag_d = timeout_hit;
        end
        if (clear_all) begin
            to_flag_d = 1'b0;
        end
    end

    // Timer registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            to_cnt_q  <= '0;
            to_flag_q <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            to_flag_q <= to_flag_d;
        end
    end
`else
    logic unused_timeout_cfg;

    assign timeout_hit        = 1'b0;
    assign debug_lsb          = invalid_q;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    assign state        = state_q;
    assign p1_ready     = (state_q == ST_COLLECT) && !p1_cap_q;
    assign p2_ready     = (state_q == ST_COLLECT) && !p2_cap_q;
    assign round_valid  = (state_q == ST_ROUND_DONE);
    assign round_winner = round_winner_q;
    assign p1_score     = p1_score_q;
    assign p2_score     = p2_score_q;
    assign round_cnt    = round_cnt_q;
    assign match_done   = (state_q == ST_MATCH_DONE);
    assign match_winner = !match_done                ? 2'b00 :
                          (p1_score_q > p2_score_q)  ? 2'b01 :
                          (p2_score_q > p1_score_q)  ? 2'b10 : 2'b00;
    assign debug        = {p1_cap_q, p2_cap_q, debug_lsb};

endmodule

// File: tb/tb_sps_match_referee.sv
// Directed bench for sps_match_referee: a default N=3 instance and an N=5
// instance share stimulus; each scenario task checks the instance it targets.
module tb_sps_match_referee;

    localparam logic [2:0] ST_IDLE       = 3'b000;
    localparam logic [2:0] ST_COLLECT    = 3'b001;
    localparam logic [2:0] ST_EVAL       = 3'b010;
    localparam logic [2:0] ST_ROUND_DONE = 3'b011;
    localparam logic [2:0] ST_MATCH_DONE = 3'b100;

    logic       clk = 1'b0;
    logic       reset_n, start_match, abort, p1_valid, p2_valid;
    logic [2:0] p1_move, p2_move;

    logic       d3_p1_ready, d3_p2_ready, d3_round_valid, d3_match_done;
    logic [1:0] d3_round_winner, d3_match_winner;
    logic [3:0] d3_p1_score, d3_p2_score, d3_round_cnt;
    logic [2:0] d3_state, d3_debug;

    logic       d5_p1_ready, d5_p2_ready, d5_round_valid, d5_match_done;
    logic [1:0] d5_round_winner, d5_match_winner;
    logic [3:0] d5_p1_score, d5_p2_score, d5_round_cnt;
    logic [2:0] d5_state, d5_debug;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    sps_match_referee #(.TIMEOUT_CYCLES(10)) dut3 (
        .clk(clk), .reset_n(reset_n), .start_match(start_match), .abort(abort),
        .p1_move(p1_move[1:0]), .p1_valid(p1_valid), .p1_ready(d3_p1_ready),
        .p2_move(p2_move[1:0]), .p2_valid(p2_valid), .p2_ready(d3_p2_ready),
        .round_valid(d3_round_valid), .round_winner(d3_round_winner),
        .p1_score(d3_p1_score), .p2_score(d3_p2_score), .round_cnt(d3_round_cnt),
        .match_done(d3_match_done), .match_winner(d3_match_winner),
        .state(d3_state), .debug(d3_debug)
    );

    sps_match_referee #(.NUM_MOVES(5), .MOVE_W(3)) dut5 (
        .clk(clk), .reset_n(reset_n), .start_match(start_match), .abort(abort),
        .p1_move(p1_move), .p1_valid(p1_valid), .p1_ready(d5_p1_ready),
        .p2_move(p2_move), .p2_valid(p2_valid), .p2_ready(d5_p2_ready),
        .round_valid(d5_round_valid), .round_winner(d5_round_winner),
        .p1_score(d5_p1_score), .p2_score(d5_p2_score), .round_cnt(d5_round_cnt),
        .match_done(d5_match_done), .match_winner(d5_match_winner),
        .state(d5_state), .debug(d5_debug)
    );

    function automatic logic [25:0] all3();
        return {d3_state, d3_round_valid, d3_round_winner, d3_p1_score, d3_p2_score,
                d3_round_cnt, d3_match_done, d3_match_winner, d3_debug, d3_p1_ready, d3_p2_ready};
    endfunction

    function automatic logic [25:0] all5();
        return {d5_state, d5_round_valid, d5_round_winner, d5_p1_score, d5_p2_score,
                d5_round_cnt, d5_match_done, d5_match_winner, d5_debug, d5_p1_ready, d5_p2_ready};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Both players submit on the same cycle; returns with the DUT in ROUND_DONE.
    task automatic play(input logic [2:0] a, input logic [2:0] b);
        p1_move  = a;
        p2_move  = b;
        p1_valid = 1'b1;
        p2_valid = 1'b1;
        tick();
        p1_valid = 1'b0;
        p2_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start_match = 1'b0; abort = 1'b0;
        p1_valid = 1'b0; p2_valid = 1'b0; p1_move = 3'd0; p2_move = 3'd0;
        tick();
        tick();
        reset_n = 1'b1;
        tests_run++;
        if (all3() !== 26'd0) begin
            tests_failed++; $display("FAIL reset_n3: got %h expected 0", all3());
        end
        tests_run++;
        if (all5() !== 26'd0) begin
            tests_failed++; $display("FAIL reset_n5: got %h expected 0", all5());
        end
    endtask

    task automatic test_p1_sweep();
        start_match = 1'b1;
        tick();
        start_match = 1'b0;
        tests_run++;
        if (d3_state !== ST_COLLECT) begin
            tests_failed++; $display("FAIL sweep_start: state %0d expected %0d", d3_state, ST_COLLECT);
        end
        for (int i = 0; i < 3; i++) begin
            play(3'd1, 3'd0);
            tests_run++;
            if ({d3_round_valid, d3_round_winner} !== 3'b101) begin
                tests_failed++; $display("FAIL sweep_round%0d: valid/winner %b expected 101", i, {d3_round_valid, d3_round_winner});
            end
            tests_run++;
            if ({d3_p1_score, d3_p2_score, d3_round_cnt} !== {4'(i + 1), 4'd0, 4'(i + 1)}) begin
                tests_failed++; $display("FAIL sweep_score%0d: p1/p2/cnt %h expected %h", i,
                    {d3_p1_score, d3_p2_score, d3_round_cnt}, {4'(i + 1), 4'd0, 4'(i + 1)});
            end
            tick();
            if (i < 2) begin
                tests_run++;
                if (d3_state !== ST_COLLECT) begin
                    tests_failed++; $display("FAIL sweep_next%0d: state %0d expected %0d", i, d3_state, ST_COLLECT);
                end
            end
        end
        tests_run++;
        if ({d3_state, d3_match_done, d3_match_winner} !== {ST_MATCH_DONE, 1'b1, 2'b01}) begin
            tests_failed++; $display("FAIL sweep_match: state/done/winner %b expected 100101",
                {d3_state, d3_match_done, d3_match_winner});
        end
    endtask

    task automatic test_tie_latency();
        start_match = 1'b1;
        tick();
        start_match = 1'b0;
        tests_run++;
        if ({d3_state, d3_p1_score, d3_round_cnt, d3_round_winner, d3_p1_ready, d3_p2_ready}
                !== {ST_COLLECT, 4'd0, 4'd0, 2'b00, 2'b11}) begin
            tests_failed++; $display("FAIL restart_clear: got %b", {d3_state, d3_p1_score, d3_round_cnt,
                d3_round_winner, d3_p1_ready, d3_p2_ready});
        end
        p1_move = 3'd0; p2_move = 3'd0; p1_valid = 1'b1; p2_valid = 1'b1;
        tick();
        p1_valid = 1'b0; p2_valid = 1'b0;
        tests_run++;
        if ({d3_state, d3_round_valid, d3_debug[2:1], d3_p1_ready, d3_p2_ready} !== {ST_EVAL, 1'b0, 2'b11, 2'b00}) begin
            tests_failed++; $display("FAIL tie_eval: got %b expected 010011 00",
                {d3_state, d3_round_valid, d3_debug[2:1], d3_p1_ready, d3_p2_ready});
        end
        tick();
        tests_run++;
        if ({d3_round_valid, d3_round_winner, d3_p1_score, d3_p2_score, d3_round_cnt}
                !== {1'b1, 2'b00, 4'd0, 4'd0, 4'd1}) begin
            tests_failed++; $display("FAIL tie_result: got %h", {d3_round_valid, d3_round_winner,
                d3_p1_score, d3_p2_score, d3_round_cnt});
        end
        tick();
        tests_run++;
        if ({d3_round_valid, d3_state} !== {1'b0, ST_COLLECT}) begin
            tests_failed++; $display("FAIL tie_pulse: valid/state %b expected 0001", {d3_round_valid, d3_state});
        end
    endtask

    task automatic test_capture_order();
        p1_move = 3'd2; p1_valid = 1'b1; start_match = 1'b1;
        tick();
        start_match = 1'b0;
        tests_run++;
        if ({d3_state, d3_round_cnt, d3_p1_ready, d3_p2_ready, d3_debug[2:1]}
                !== {ST_COLLECT, 4'd1, 2'b01, 2'b10}) begin
            tests_failed++; $display("FAIL order_p1_first: got %b", {d3_state, d3_round_cnt,
                d3_p1_ready, d3_p2_ready, d3_debug[2:1]});
        end
        p1_move = 3'd0;
        tick();
        tests_run++;
        if (d3_state !== ST_COLLECT) begin
            tests_failed++; $display("FAIL order_wait: state %0d expected %0d", d3_state, ST_COLLECT);
        end
        p1_valid = 1'b0; p2_move = 3'd1; p2_valid = 1'b1;
        tick();
        p2_valid = 1'b0;
        tests_run++;
        if (d3_state !== ST_EVAL) begin
            tests_failed++; $display("FAIL order_eval: state %0d expected %0d", d3_state, ST_EVAL);
        end
        tick();
        tests_run++;
        if ({d3_round_winner, d3_p1_score, d3_round_cnt} !== {2'b01, 4'd1, 4'd2}) begin
            tests_failed++; $display("FAIL order_keep: winner/p1/cnt %h expected 112",
                {d3_round_winner, d3_p1_score, d3_round_cnt});
        end
        tick();
    endtask

    task automatic test_invalid();
        play(3'd3, 3'd2);
        tests_run++;
        if ({d3_round_winner, d3_p1_score, d3_p2_score, d3_round_cnt} !== {2'b10, 4'd1, 4'd1, 4'd3}) begin
            tests_failed++; $display("FAIL forfeit_p1: got %h expected 2113",
                {d3_round_winner, d3_p1_score, d3_p2_score, d3_round_cnt});
        end
        tick();
        play(3'd3, 3'd3);
        tests_run++;
        if ({d3_round_winner, d3_p1_score, d3_p2_score, d3_round_cnt} !== {2'b11, 4'd1, 4'd1, 4'd3}) begin
            tests_failed++; $display("FAIL void_round: got %h expected 3113",
                {d3_round_winner, d3_p1_score, d3_p2_score, d3_round_cnt});
        end
`ifndef SPS_TIMEOUT_EN
        tests_run++;
        if (d3_debug !== 3'b111) begin
            tests_failed++; $display("FAIL void_debug: got %b expected 111", d3_debug);
        end
`endif
        tick();
        play(3'd0, 3'd3);
        tests_run++;
        if ({d3_round_winner, d3_p1_score, d3_round_cnt} !== {2'b01, 4'd2, 4'd4}) begin
            tests_failed++; $display("FAIL forfeit_p2: got %h expected 124",
                {d3_round_winner, d3_p1_score, d3_round_cnt});
        end
        tick();
    endtask

    task automatic test_abort();
        p1_move = 3'd1; p1_valid = 1'b1;
        tick();
        p1_valid = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tests_run++;
        if (all3() !== 26'd0) begin
            tests_failed++; $display("FAIL abort_clear: got %h expected 0", all3());
        end
    endtask

    task automatic test_seven_ties();
        start_match = 1'b1;
        tick();
        start_match = 1'b0;
        for (int i = 0; i < 7; i++) begin
            play(3'd0, 3'd0);
            tests_run++;
            if ({d3_round_winner, d3_round_cnt} !== {2'b00, 4'(i + 1)}) begin
                tests_failed++; $display("FAIL ties_round%0d: winner/cnt %h expected %h", i,
                    {d3_round_winner, d3_round_cnt}, {2'b00, 4'(i + 1)});
            end
            tick();
            if (i < 6) begin
                tests_run++;
                if (d3_state !== ST_COLLECT) begin
                    tests_failed++; $display("FAIL ties_next%0d: state %0d expected %0d", i, d3_state, ST_COLLECT);
                end
            end
        end
        tests_run++;
        if ({d3_state, d3_match_done, d3_match_winner, d3_round_cnt} !== {ST_MATCH_DONE, 1'b1, 2'b00, 4'd7}) begin
            tests_failed++; $display("FAIL ties_match: got %b", {d3_state, d3_match_done, d3_match_winner, d3_round_cnt});
        end
    endtask

    task automatic test_n5();
        logic [2:0] m1 [4];
        logic [2:0] m2 [4];
        logic [1:0] exp_w [4];
        m1 = '{3'd0, 3'd0, 3'd0, 3'd2};
        m2 = '{3'd3, 3'd4, 3'd1, 3'd0};
        exp_w = '{2'b01, 2'b01, 2'b10, 2'b01};
        start_match = 1'b1;
        tick();
        start_match = 1'b0;
        for (int i = 0; i < 4; i++) begin
            play(m1[i], m2[i]);
            tests_run++;
            if ({d5_round_valid, d5_round_winner} !== {1'b1, exp_w[i]}) begin
                tests_failed++; $display("FAIL n5_round%0d: valid/winner %b expected %b", i,
                    {d5_round_valid, d5_round_winner}, {1'b1, exp_w[i]});
            end
            tick();
        end
        tests_run++;
        if ({d5_p1_score, d5_p2_score, d5_round_cnt} !== {4'd3, 4'd1, 4'd4}) begin
            tests_failed++; $display("FAIL n5_scores: got %h expected 314", {d5_p1_score, d5_p2_score, d5_round_cnt});
        end
        tests_run++;
        if ({d5_state, d5_match_winner} !== {ST_MATCH_DONE, 2'b01}) begin
            tests_failed++; $display("FAIL n5_match: state/winner %b expected 10001", {d5_state, d5_match_winner});
        end
    endtask

    task automatic test_reset_mid_eval();
        start_match = 1'b1;
        tick();
        start_match = 1'b0;
        play(3'd1, 3'd0);
        tick();
        p1_move = 3'd0; p2_move = 3'd0; p1_valid = 1'b1; p2_valid = 1'b1;
        tick();
        p1_valid = 1'b0; p2_valid = 1'b0;
        tests_run++;
        if ({d5_state, d5_p1_score, d5_round_winner} !== {ST_EVAL, 4'd1, 2'b01}) begin
            tests_failed++; $display("FAIL mid_eval_setup: got %b", {d5_state, d5_p1_score, d5_round_winner});
        end
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tests_run++;
        if (all5() !== 26'd0) begin
            tests_failed++; $display("FAIL mid_eval_reset5: got %h expected 0", all5());
        end
        tests_run++;
        if (all3() !== 26'd0) begin
            tests_failed++; $display("FAIL mid_eval_reset3: got %h expected 0", all3());
        end
    endtask

`ifdef SPS_TIMEOUT_EN
    task automatic test_timeout();
        start_match = 1'b1;
        tick();
        start_match = 1'b0;
        p2_move = 3'd1; p2_valid = 1'b1;
        tick();
        p2_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
        end
        tests_run++;
        if (d3_state !== ST_COLLECT) begin
            tests_failed++; $display("FAIL timeout_early: state %0d expected %0d", d3_state, ST_COLLECT);
        end
        tick();
        tests_run++;
        if (d3_state !== ST_EVAL) begin
            tests_failed++; $display("FAIL timeout_fire: state %0d expected %0d", d3_state, ST_EVAL);
        end
        tick();
        tests_run++;
        if ({d3_round_winner, d3_p2_score, d3_round_cnt, d3_debug} !== {2'b10, 4'd1, 4'd1, 3'b011}) begin
            tests_failed++; $display("FAIL timeout_result: got %b", {d3_round_winner, d3_p2_score, d3_round_cnt, d3_debug});
        end
    endtask
`endif

    initial begin
        test_reset();
        test_p1_sweep();
        test_tie_latency();
        test_capture_order();
        test_invalid();
        test_abort();
        test_seven_ties();
        test_n5();
        test_reset_mid_eval();
`ifdef SPS_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
